// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM with glitch
// rejection and break handling, and a one-entry ready/valid holding register.
`timescale 1ns/1ps

module uart_rx #(
   parameter int CLKS_PER_BIT = 867,
   parameter bit MSB_FIRST    = 1'b1
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic [7:0] o_Data,
   output logic       o_Valid,
   input  logic       i_Ready,
   output logic       o_Framing_Err,
   output logic       o_Overrun,
   output logic       o_Busy
);

   localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 21) ? $clog2(CLKS_PER_BIT) : 21;
   localparam logic [CNT_W-1:0] HALF_C = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_e;

   logic             sync1_q, sync2_q;
   logic             rx_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             deliver_q, deliver_d;
   logic             frm_q, frm_d;
   logic             valid_q, valid_d;
   logic [7:0]       data_q, data_d;
   logic             ovr_q, ovr_d;

   // Synchronizer resets to the idle (high) line level so reset never fakes a start bit.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= i_Rx_Serial;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         deliver_q <= 1'b0;
         frm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         deliver_q <= deliver_d;
         frm_q     <= frm_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      deliver_d = 1'b0;
      frm_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            if (!rx_s) begin
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            // Start bit must still be low at its midpoint, otherwise it was a glitch.
            if (cnt_q == HALF_C) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               if (!rx_s) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_C) begin
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 3'd1;
               if (MSB_FIRST) begin
                  shift_d = {shift_q[6:0], rx_s};
               end else begin
                  shift_d = {rx_s, shift_q[7:1]};
               end
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST_C) begin
               cnt_d = '0;
               if (rx_s) begin
                  deliver_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  frm_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end
         S_BREAK: begin
            // A held-low line is one break, not a stream of frames.
            cnt_d = '0;
            if (rx_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
         end
      endcase
   end

   // Holding register; a reset discards any byte not yet consumed.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovr_d   = 1'b0;
      if (deliver_q) begin
         // A same-cycle accept frees the slot, so the new byte replaces the old one.
         if (!valid_q || i_Ready) begin
            valid_d = 1'b1;
            data_d  = shift_q;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_Ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign o_Data        = data_q;
   assign o_Valid       = valid_q;
   assign o_Framing_Err = frm_q;
   assign o_Overrun     = ovr_q;
   assign o_Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: one MSB-first and one
// LSB-first instance, each driven by hand-built 8N1 frames.
`timescale 1ns/1ps

module tb_uart_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rx_m, rx_l, rdy_m, rdy_l;
   logic [7:0] data_m, data_l;
   logic       val_m, val_l, frm_m, frm_l, ovr_m, ovr_l, busy_m, busy_l;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   uart_rx #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b1)) u_m (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_m), .o_Data(data_m),
      .o_Valid(val_m), .i_Ready(rdy_m), .o_Framing_Err(frm_m),
      .o_Overrun(ovr_m), .o_Busy(busy_m));

   uart_rx #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b0)) u_l (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_l), .o_Data(data_l),
      .o_Valid(val_l), .i_Ready(rdy_l), .o_Framing_Err(frm_l),
      .o_Overrun(ovr_l), .o_Busy(busy_l));

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitors sampled mid-cycle: valid rise time/falls, error-pulse cycle counts.
   int   rise_m = -1, falls_m = 0, frm_cyc_m = 0, ovr_cyc_m = 0, both_m = 0;
   int   rise_l = -1, err_l = 0;
   logic prev_v_m = 1'b0, prev_v_l = 1'b0;
   always @(negedge clk) begin
      if (val_m && !prev_v_m) rise_m = cyc;
      if (!val_m && prev_v_m) falls_m++;
      prev_v_m = val_m;
      if (frm_m) frm_cyc_m++;
      if (ovr_m) ovr_cyc_m++;
      if (frm_m && ovr_m) both_m++;
      if (val_l && !prev_v_l) rise_l = cyc;
      prev_v_l = val_l;
      if (frm_l || ovr_l) err_l++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit which, input logic v);
      if (which) rx_l = v;
      else rx_m = v;
   endtask

   // Caller is positioned 1ns after a rising edge; line left at the stop level.
   task automatic send_frame(input bit which, input logic [7:0] b, input bit msb,
                             input logic stop, input int stop_cycles, output int start);
      start = cyc;
      set_line(which, 1'b0);
      tick(16);
      for (int i = 0; i < 8; i++) begin
         set_line(which, msb ? b[7-i] : b[i]);
         tick(16);
      end
      set_line(which, stop);
      tick(stop_cycles);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++; if (data_m !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_m); end
      checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", val_m); end
      checks++; if (frm_m !== 1'b0) begin failures++; $display("FAIL reset_frm got=%b exp=0", frm_m); end
      checks++; if (ovr_m !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr_m); end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
      checks++; if ({val_l, busy_l, data_l} !== 10'd0) begin failures++; $display("FAIL reset_lsb got=%b%b%h exp=0", val_l, busy_l, data_l); end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_msb_basic();
      int s, f0, o0;
      f0 = frm_cyc_m; o0 = ovr_cyc_m;
      rdy_m = 1'b0;
      send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 16, s);
      checks++; if (rise_m !== s + 156) begin failures++; $display("FAIL a5_rise_time got=%0d exp=%0d", rise_m, s + 156); end
      checks++; if (data_m !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", data_m); end
      checks++; if (val_m !== 1'b1) begin failures++; $display("FAIL a5_valid got=%b exp=1", val_m); end
      checks++; if (frm_cyc_m !== f0 || ovr_cyc_m !== o0) begin failures++; $display("FAIL a5_no_err got=%0d/%0d exp=%0d/%0d", frm_cyc_m, ovr_cyc_m, f0, o0); end
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL a5_busy got=%b exp=0", busy_m); end
      rdy_m = 1'b1;
      tick(1);
      rdy_m = 1'b0;
      checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL a5_consume_valid got=%b exp=0", val_m); end
      checks++; if (data_m !== 8'hA5) begin failures++; $display("FAIL a5_data_hold got=%h exp=a5", data_m); end
   endtask

   task automatic test_bit_order();
      int s, e0;
      e0 = err_l;
      send_frame(1'b1, 8'h3C, 1'b0, 1'b1, 16, s);
      checks++; if (data_l !== 8'h3C || val_l !== 1'b1) begin failures++; $display("FAIL lsb_3c got=%h/%b exp=3c/1", data_l, val_l); end
      checks++; if (rise_l !== s + 156) begin failures++; $display("FAIL lsb_rise_time got=%0d exp=%0d", rise_l, s + 156); end
      checks++; if (err_l !== e0) begin failures++; $display("FAIL lsb_no_err got=%0d exp=%0d", err_l, e0); end
      send_frame(1'b0, 8'hCC, 1'b1, 1'b1, 16, s);
      checks++; if (data_m !== 8'hCC || val_m !== 1'b1) begin failures++; $display("FAIL msb_cc got=%h/%b exp=cc/1", data_m, val_m); end
      rdy_m = 1'b1; rdy_l = 1'b1;
      tick(1);
      rdy_m = 1'b0; rdy_l = 1'b0;
   endtask

   task automatic test_glitch();
      int s, r0;
      r0 = rise_m;
      set_line(1'b0, 1'b0);
      tick(5);
      checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL glitch_busy_start got=%b exp=1", busy_m); end
      set_line(1'b0, 1'b1);
      tick(10);
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL glitch_busy_idle got=%b exp=0", busy_m); end
      checks++; if (val_m !== 1'b0 || rise_m !== r0) begin failures++; $display("FAIL glitch_no_byte got=%b exp=0", val_m); end
      send_frame(1'b0, 8'h55, 1'b1, 1'b1, 16, s);
      checks++; if (data_m !== 8'h55 || val_m !== 1'b1) begin failures++; $display("FAIL glitch_next_55 got=%h/%b exp=55/1", data_m, val_m); end
      rdy_m = 1'b1; tick(1); rdy_m = 1'b0;
   endtask

   task automatic test_break();
      int s, f0, o0;
      f0 = frm_cyc_m; o0 = ovr_cyc_m;
      send_frame(1'b0, 8'h0F, 1'b1, 1'b0, 40, s);
      checks++; if (frm_cyc_m !== f0 + 1) begin failures++; $display("FAIL break_frm_pulse got=%0d exp=%0d", frm_cyc_m - f0, 1); end
      checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL break_valid got=%b exp=0", val_m); end
      checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL break_held got=%b exp=1", busy_m); end
      set_line(1'b0, 1'b1);
      tick(5);
      checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", busy_m); end
      send_frame(1'b0, 8'h81, 1'b1, 1'b1, 16, s);
      checks++; if (data_m !== 8'h81 || val_m !== 1'b1) begin failures++; $display("FAIL break_next_81 got=%h/%b exp=81/1", data_m, val_m); end
      checks++; if (frm_cyc_m !== f0 + 1 || ovr_cyc_m !== o0) begin failures++; $display("FAIL break_err_total got=%0d/%0d exp=%0d/%0d", frm_cyc_m, ovr_cyc_m, f0 + 1, o0); end
      rdy_m = 1'b1; tick(1); rdy_m = 1'b0;
   endtask

   task automatic test_back_to_back();
      int s, s2, o0, fl;
      o0 = ovr_cyc_m;
      send_frame(1'b0, 8'h11, 1'b1, 1'b1, 16, s);
      send_frame(1'b0, 8'h22, 1'b1, 1'b1, 16, s2);
      checks++; if (data_m !== 8'h11 || val_m !== 1'b1) begin failures++; $display("FAIL b2b_retain got=%h/%b exp=11/1", data_m, val_m); end
      checks++; if (ovr_cyc_m !== o0 + 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ovr_cyc_m - o0); end
      rdy_m = 1'b1; tick(1); rdy_m = 1'b0;
      checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL b2b_consume got=%b exp=0", val_m); end
      send_frame(1'b0, 8'h11, 1'b1, 1'b1, 16, s);
      fl = falls_m; o0 = ovr_cyc_m;
      fork
         send_frame(1'b0, 8'h22, 1'b1, 1'b1, 16, s2);
         begin
            tick(155);
            rdy_m = 1'b1;
            tick(1);
            rdy_m = 1'b0;
         end
      join
      checks++; if (data_m !== 8'h22 || val_m !== 1'b1) begin failures++; $display("FAIL b2b_replace got=%h/%b exp=22/1", data_m, val_m); end
      checks++; if (falls_m !== fl) begin failures++; $display("FAIL b2b_valid_steady got=%0d falls exp=0", falls_m - fl); end
      checks++; if (ovr_cyc_m !== o0) begin failures++; $display("FAIL b2b_no_overrun got=%0d exp=0", ovr_cyc_m - o0); end
   endtask

   task automatic test_reset_mid();
      int s, f0, o0;
      checks++; if (val_m !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", val_m); end
      fork
         send_frame(1'b0, 8'hFF, 1'b1, 1'b1, 16, s);
         begin
            tick(85);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            checks++; if (data_m !== 8'h00 || val_m !== 1'b0) begin failures++; $display("FAIL mid_rst_hold got=%h/%b exp=00/0", data_m, val_m); end
            checks++; if (frm_m !== 1'b0 || ovr_m !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b/%b exp=0/0", frm_m, ovr_m); end
            checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy_m); end
         end
      join
      f0 = frm_cyc_m; o0 = ovr_cyc_m;
      checks++; if (val_m !== 1'b0) begin failures++; $display("FAIL mid_abandoned got=%b exp=0", val_m); end
      send_frame(1'b0, 8'hE7, 1'b1, 1'b1, 16, s);
      checks++; if (data_m !== 8'hE7 || val_m !== 1'b1) begin failures++; $display("FAIL mid_next_e7 got=%h/%b exp=e7/1", data_m, val_m); end
      checks++; if (frm_cyc_m !== f0 || ovr_cyc_m !== o0) begin failures++; $display("FAIL mid_no_err got=%0d/%0d exp=%0d/%0d", frm_cyc_m, ovr_cyc_m, f0, o0); end
   endtask

   initial begin
      rst = 1'b1; rx_m = 1'b1; rx_l = 1'b1; rdy_m = 1'b0; rdy_l = 1'b0;
      test_reset();
      test_msb_basic();
      test_bit_order();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_mid();
      checks++; if (both_m !== 0) begin failures++; $display("FAIL err_exclusive got=%0d exp=0", both_m); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
